// File: rtl/myproject_mul_pipe_rs.sv
// Pipelined signed multiplier with valid/ready handshake. The full product is
// rescaled by an arithmetic right shift with optional rounding and saturation.
module myproject_mul_pipe_rs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 22,
  parameter int din1_WIDTH = 21,
  parameter int dout_WIDTH = 24,
  parameter int SHIFT      = 12,
  parameter int RND_MODE   = 1,
  parameter int SAT_MODE   = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int P      = din0_WIDTH + din1_WIDTH;
  localparam int W      = P + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W-1:0] RND_ADD =
    (RND_MODE != 0 && SHIFT > 0) ? (W'(1) <<< RND_SH) : '0;

  logic                         r_out_valid;
  logic signed [dout_WIDTH-1:0] r_dout;
  logic                         r_ovf;

  logic                         w_en;
  logic signed [P-1:0]          w_prod;
  logic signed [P-1:0]          w_scale_in;
  logic                         w_scale_vld;
  logic signed [W-1:0]          w_rnd;
  logic signed [W-1:0]          w_r;
  logic signed [dout_WIDTH-1:0] w_dout;
  logic                         w_ovf;

  // One enable for every stage: the whole pipe stalls only when the output is stuck.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;
  assign w_prod   = P'(din0) * P'(din1);

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign w_scale_in  = w_prod;
      assign w_scale_vld = in_valid;
    end else begin : g_pipe
      logic signed [P-1:0]  r_prod [NUM_STAGE-1];
      logic [NUM_STAGE-2:0] r_vld;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_vld <= '0;
        end else if (w_en) begin
          r_vld[0] <= in_valid;
          for (int i = 1; i < NUM_STAGE - 1; i++) r_vld[i] <= r_vld[i-1];
        end
      end

      // NOTE: data registers carry no reset; only the valid bits decide what is live.
      always_ff @(posedge ap_clk) begin
        if (w_en) begin
          r_prod[0] <= w_prod;
          for (int i = 1; i < NUM_STAGE - 1; i++) r_prod[i] <= r_prod[i-1];
        end
      end

      assign w_scale_in  = r_prod[NUM_STAGE-2];
      assign w_scale_vld = r_vld[NUM_STAGE-2];
    end
  endgenerate

  // One extra bit of headroom so the rounding constant can never overflow.
  assign w_rnd = {w_scale_in[P-1], w_scale_in} + RND_ADD;
  assign w_r   = w_rnd >>> SHIFT;

  generate
    if (dout_WIDTH >= W - SHIFT) begin : g_fits
      assign w_dout = dout_WIDTH'(w_r);
      assign w_ovf  = 1'b0;
    end else begin : g_clip
      localparam logic signed [dout_WIDTH-1:0] MAX_V = {1'b0, {(dout_WIDTH-1){1'b1}}};
      localparam logic signed [dout_WIDTH-1:0] MIN_V = {1'b1, {(dout_WIDTH-1){1'b0}}};
      logic [W-dout_WIDTH:0] w_hi;
      logic                  w_fits;

      // Representable iff every bit from the result sign position upward agrees.
      assign w_hi   = w_r[W-1:dout_WIDTH-1];
      assign w_fits = (&w_hi) || !(|w_hi);
      assign w_ovf  = !w_fits;

      if (SAT_MODE != 0) begin : g_sat
        assign w_dout = w_fits ? w_r[dout_WIDTH-1:0] : (w_r[W-1] ? MIN_V : MAX_V);
      end else begin : g_wrap
        assign w_dout = w_r[dout_WIDTH-1:0];
      end
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_scale_vld;
      if (w_scale_vld) begin
        r_dout <= w_dout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_myproject_mul_pipe_rs.sv
// Bench for myproject_mul_pipe_rs: six parameter variants share one stimulus
// stream, each with its own queue-based scoreboard fed by an arithmetic model.
module tb_myproject_mul_pipe_rs;

  localparam int NI    = 6;
  localparam int DW    = 24;
  localparam int NSMAX = 5;
  localparam int NS_T  [NI] = '{3, 3, 3, 3, 1, 5};
  localparam int SH_T  [NI] = '{12, 12, 1, 1, 12, 12};
  localparam int RND_T [NI] = '{1, 1, 1, 0, 1, 1};
  localparam int SAT_T [NI] = '{1, 0, 1, 1, 1, 1};

  typedef struct {
    longint d;
    bit     o;
    longint tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [21:0] din0 = '0;
  logic signed [20:0] din1 = '0;
  logic [NI-1:0] in_ready_v, out_valid_v, ovf_v;
  logic signed [DW-1:0] dout_a [NI];

  int     n_chk = 0;
  int     n_bad = 0;
  int     n_deliv [NI] = '{default: 0};
  int     base    [NI] = '{default: 0};
  int     pend    [NI] = '{default: 0};
  longint last_d  [NI] = '{default: 0};
  bit     last_o  [NI] = '{default: 0};

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: exact product, shift with optional half-up rounding, then clip or wrap.
  function automatic void ref_calc(input longint a, input longint b, input int sh,
                                   input int rnd, input int sat,
                                   output longint d, output bit o);
    longint p, r, mx, mn;
    p  = a * b;
    if (rnd != 0 && sh > 0) r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    else                    r = p >>> sh;
    mx = (longint'(1) <<< (DW - 1)) - 1;
    mn = -mx - 1;
    o  = (r > mx) || (r < mn);
    if (sat != 0) begin
      d = (r > mx) ? mx : ((r < mn) ? mn : r);
    end else begin
      d = r & ((longint'(1) <<< DW) - 1);
      if (d > mx) d = d - (longint'(1) <<< DW);
    end
  endfunction

  function automatic logic signed [21:0] rand_a();
    case ($urandom_range(0, 5))
      0:       return 22'sh1FFFFF;
      1:       return 22'sh200000;
      default: return 22'($urandom);
    endcase
  endfunction

  function automatic logic signed [20:0] rand_b();
    case ($urandom_range(0, 5))
      0:       return 21'sh0FFFFF;
      1:       return 21'sh100000;
      default: return 21'($urandom);
    endcase
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    myproject_mul_pipe_rs #(
      .ID(k), .NUM_STAGE(NS_T[k]), .din0_WIDTH(22), .din1_WIDTH(21),
      .dout_WIDTH(DW), .SHIFT(SH_T[k]), .RND_MODE(RND_T[k]), .SAT_MODE(SAT_T[k])
    ) u_dut (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_v[k]),
      .din0(din0), .din1(din1),
      .out_valid(out_valid_v[k]), .out_ready(out_ready),
      .dout(dout_a[k]), .ovf(ovf_v[k])
    );

    exp_t   q[$];
    longint en_cnt = 0;

    // Mid-cycle monitor: what is visible now is what the next rising edge samples.
    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        q.delete();
      end else begin
        check($sformatf("ready%0d", k), in_ready_v[k], !out_valid_v[k] || out_ready);
        if (out_valid_v[k] && out_ready) begin
          check($sformatf("stale%0d", k), q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("dout%0d", k), dout_a[k], e.d);
            check($sformatf("ovf%0d", k), ovf_v[k], e.o);
            check($sformatf("lat%0d", k), en_cnt - e.tag, NS_T[k]);
          end
          last_d[k] = dout_a[k];
          last_o[k] = ovf_v[k];
          n_deliv[k]++;
        end
        if (in_valid && in_ready_v[k]) begin
          ref_calc(din0, din1, SH_T[k], RND_T[k], SAT_T[k], e.d, e.o);
          e.tag = en_cnt;
          q.push_back(e);
        end
        if (in_ready_v[k]) en_cnt++;
      end
      pend[k] = q.size();
    end
  end

  task automatic one_beat(input longint a, input longint b);
    for (int k = 0; k < NI; k++) base[k] = n_deliv[k];
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din0      = 22'(a);
    din1      = 21'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (NSMAX + 2) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int k, input longint d, input bit o);
    check({tag, "_n"}, n_deliv[k] - base[k], 1);
    check(tag, last_d[k], d);
    check({tag, "_ovf"}, last_o[k], o);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    bit took;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_valid", out_valid_v[k], 0);
      check("rst_dout", dout_a[k], 0);
      check("rst_ovf", ovf_v[k], 0);
    end
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", in_ready_v, 6'h3F);

    // Reset with beats in flight
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din0 = rand_a();
      din1 = rand_b();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid_v, 0);
    check("rst_async_dout", dout_a[4], 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) base[k] = n_deliv[k];
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check("no_stale", n_deliv[k] - base[k], 0);

    // Rounding vs truncation at SHIFT=1
    one_beat(3, 5);
    expect_out("rnd_pos", 2, 8, 1'b0);
    expect_out("trn_pos", 3, 7, 1'b0);
    one_beat(-3, 5);
    expect_out("rnd_neg", 2, -7, 1'b0);
    expect_out("trn_neg", 3, -8, 1'b0);

    // Saturation and wrap
    one_beat(2097151, 1048575);
    expect_out("sat_max", 0, 8388607, 1'b1);
    expect_out("wrap_max", 1, -768, 1'b1);
    one_beat(-2097152, 1048575);
    expect_out("sat_min", 0, -8388608, 1'b1);
    expect_out("wrap_min", 1, 512, 1'b1);

    // Most positive product 2^41
    one_beat(-2097152, -1048576);
    expect_out("corner", 0, 8388607, 1'b1);
    expect_out("corner_wrap", 1, 0, 1'b1);
    expect_out("corner_ns1", 4, 8388607, 1'b1);
    expect_out("corner_ns5", 5, 8388607, 1'b1);

    // Random back-pressure
    for (int k = 0; k < NI; k++) base[k] = n_deliv[k];
    sent = 0;
    @(posedge clk); #1;
    din0      = rand_a();
    din1      = rand_b();
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 2000 && sent < 20; cyc++) begin
      @(negedge clk);
      took = in_valid && in_ready_v[0];
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (took) begin
        sent++;
        if (sent < 20) begin
          din0 = rand_a();
          din1 = rand_b();
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 20);
    repeat (NSMAX + 4) @(posedge clk);
    #1;
    check("bp_deliv0", n_deliv[0] - base[0], 20);
    for (int k = 0; k < NI; k++) check("bp_drained", pend[k], 0);

    // Full rate
    for (int k = 0; k < NI; k++) base[k] = n_deliv[k];
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din0 = rand_a();
      din1 = rand_b();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (NSMAX + 2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("fr_count", n_deliv[k] - base[k], 100);
      check("fr_drained", pend[k], 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
